// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the program loader
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHK   = 3'd2,
        S_FLUSH = 3'd3,
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam int INSTR_W        = 16;
    localparam int MAX_WORDS_DEF  = 2048;
    localparam int BYTES_PER_WORD = 2;
    localparam int CNT_W          = 12;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - instruction stream in, instruction-memory write port out
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 16
) ();

    logic [INSTR_W-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_wdata;
    logic               mem_we;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/prog_loader_chksum.sv
// rtl/prog_loader_chksum.sv - 16-bit modular checksum accumulator (PROG_CHECKSUM_EN builds only)
`ifdef PROG_CHECKSUM_EN
module prog_chksum
    import prog_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rstz,
    input  logic               i_clr,
    input  logic               i_add,
    input  logic [INSTR_W-1:0] i_data,
    output logic               o_zero
);

    logic [INSTR_W-1:0] r_acc;
    logic [INSTR_W-1:0] w_sum;

    // Zero flag includes the word on i_data so the checksum word can be judged on its own accept cycle.
    assign w_sum  = r_acc + i_data;
    assign o_zero = (w_sum == '0);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= w_sum;
        end
    end

endmodule
`endif

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a program into instruction memory, then releases the core from reset.
// Optional trailing checksum word enabled by PROG_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int              ADDR_W     = 16,
    parameter int              MAX_WORDS  = MAX_WORDS_DEF,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic              ld_start,
    input  logic [CNT_W-1:0]  ld_len,
    prog_loader_if.slave      bus,
    output logic              cpu_rstz,
    output logic [ADDR_W-1:0] pc_init,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t             r_state, w_state_nxt, w_start_dec;
    logic [CNT_W-1:0]   r_cnt, r_len;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [INSTR_W-1:0] r_wdata;
    logic               r_cpu_rstz, r_busy, r_done, r_err;
    logic               w_accept, w_last, w_load_clr, w_word_wr;

    assign bus.in_ready = (r_state == S_LOAD) || (r_state == S_CHK);
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_word_wr    = w_accept && (r_state == S_LOAD);
    assign w_last       = (r_cnt == r_len - CNT_W'(1));

`ifdef PROG_CHECKSUM_EN
    logic w_sum_zero;

    prog_chksum u_chksum (
        .clk    (clk),
        .rstz   (rstz),
        .i_clr  (w_load_clr),
        .i_add  (w_word_wr),
        .i_data (bus.in_data),
        .o_zero (w_sum_zero)
    );
`endif

    // Decode of a load request, shared by IDLE, RUN and ERR.
    always_comb begin
        w_start_dec = S_LOAD;
        if (ld_len == '0) begin
`ifdef PROG_CHECKSUM_EN
            w_start_dec = S_CHK;
`else
            w_start_dec = S_RUN;
`endif
        end else if (32'(ld_len) > MAX_WORDS) begin
            w_start_dec = S_ERR;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_clr  = 1'b0;
        case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
                if (ld_start) begin
                    w_state_nxt = w_start_dec;
                    w_load_clr  = 1'b1;
                end
            end
            S_LOAD: begin
                if (w_accept && w_last) begin
`ifdef PROG_CHECKSUM_EN
                    w_state_nxt = S_CHK;
`else
                    w_state_nxt = S_FLUSH;
`endif
                end
            end
`ifdef PROG_CHECKSUM_EN
            S_CHK: begin
                if (w_accept) begin
                    w_state_nxt = w_sum_zero ? S_FLUSH : S_ERR;
                end
            end
`endif
            S_FLUSH: w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_we       <= 1'b0;
            r_addr     <= START_ADDR;
            r_wdata    <= '0;
            r_cpu_rstz <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_load_clr) begin
                r_cnt <= '0;
                r_len <= ld_len;
            end else if (w_word_wr) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_we <= w_word_wr;
            if (w_word_wr) begin
                r_addr  <= START_ADDR + ADDR_W'(r_cnt) * ADDR_W'(BYTES_PER_WORD);
                r_wdata <= bus.in_data;
            end
            r_cpu_rstz <= (w_state_nxt == S_RUN);
            r_done     <= (w_state_nxt == S_RUN);
            r_err      <= (w_state_nxt == S_ERR);
            r_busy     <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_CHK) ||
                          (w_state_nxt == S_FLUSH);
        end
    end

    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign cpu_rstz      = r_cpu_rstz;
    assign pc_init       = START_ADDR;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader (follows PROG_CHECKSUM_EN when defined)
module tb_prog_loader;

    localparam logic [15:0] START = 16'h0000;
    // {in_ready, busy, done, err, cpu_rstz}
    localparam logic [4:0] ST_IDLE  = 5'b00000;
    localparam logic [4:0] ST_LOAD  = 5'b11000;
    localparam logic [4:0] ST_FLUSH = 5'b01000;
    localparam logic [4:0] ST_RUN   = 5'b00101;
    localparam logic [4:0] ST_ERR   = 5'b00010;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        ld_start = 1'b0;
    logic [11:0] ld_len = '0;
    logic        cpu_rstz, busy, done, err;
    logic [15:0] pc_init;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  wr_idx  = 0;
    wr_t exp_q[$];

    prog_loader_if #(.ADDR_W(16)) bus ();

    prog_loader #(.ADDR_W(16), .MAX_WORDS(2048), .START_ADDR(START)) dut (
        .clk      (clk),
        .rstz     (rstz),
        .ld_start (ld_start),
        .ld_len   (ld_len),
        .bus      (bus),
        .cpu_rstz (cpu_rstz),
        .pc_init  (pc_init),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_status(input string tag, input logic [4:0] exp);
        chk({tag, " status"}, {27'b0, bus.in_ready, busy, done, err, cpu_rstz}, {27'b0, exp});
        chk({tag, " pc_init"}, {16'b0, pc_init}, {16'b0, START});
    endtask

    // One clock of stimulus: drive, check status mid-cycle, schedule the expected write.
    task automatic tick(input logic st, input logic [11:0] len, input logic v,
                        input logic [15:0] d, input logic [4:0] exp, input logic wr,
                        input string tag);
        ld_start     = st;
        ld_len       = len;
        bus.in_valid = v;
        bus.in_data  = d;
        if (st) wr_idx = 0;
        @(negedge clk);
        chk_status(tag, exp);
        if (wr) begin
            exp_q.push_back('{START + 16'(2 * wr_idx), d, cyc + 1});
            wr_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every mem_we pulse must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected write: addr %0h data %0h (cycle %0d)",
                         bus.mem_addr, bus.mem_wdata, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("write addr", {16'b0, bus.mem_addr}, {16'b0, e.addr});
                chk("write data", {16'b0, bus.mem_wdata}, {16'b0, e.data});
                chk("write cycle", cyc, e.cyc);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("write missing mem_we", {31'b0, bus.mem_we}, 32'd1);
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_status("reset", ST_IDLE);
        chk("reset mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("reset mem_addr", {16'b0, bus.mem_addr}, {16'b0, START});
        chk("reset mem_wdata", {16'b0, bus.mem_wdata}, 32'd0);
        rstz = 1'b1;

        // three words back-to-back; in_valid in IDLE is ignored
        tick(1, 12'd3, 1, 16'hDEAD, ST_IDLE,  0, "t1 start");
        tick(0, 12'd0, 1, 16'h1111, ST_LOAD,  1, "t1 w0");
        tick(0, 12'd0, 1, 16'h2222, ST_LOAD,  1, "t1 w1");
        tick(0, 12'd0, 1, 16'h3333, ST_LOAD,  1, "t1 w2");
        tick(0, 12'd0, 0, 16'h0000, ST_FLUSH, 0, "t1 flush");
        tick(0, 12'd0, 0, 16'h0000, ST_RUN,   0, "t1 run");

        // reprogram from RUN
        tick(1, 12'd1, 0, 16'h0000, ST_RUN,   0, "t4 start");
        tick(0, 12'd0, 1, 16'hABCD, ST_LOAD,  1, "t4 w0");
        tick(0, 12'd0, 0, 16'h0000, ST_FLUSH, 0, "t4 flush");
        tick(0, 12'd0, 0, 16'h0000, ST_RUN,   0, "t4 run");

        // gapped stream
        tick(1, 12'd2, 0, 16'h0000, ST_RUN,   0, "t2 start");
        tick(0, 12'd0, 1, 16'h5A5A, ST_LOAD,  1, "t2 w0");
        tick(0, 12'd0, 0, 16'h7777, ST_LOAD,  0, "t2 gap0");
        tick(0, 12'd0, 0, 16'h8888, ST_LOAD,  0, "t2 gap1");
        tick(0, 12'd0, 1, 16'hC3C3, ST_LOAD,  1, "t2 w1");
        tick(0, 12'd0, 0, 16'h0000, ST_FLUSH, 0, "t2 flush");
        tick(0, 12'd0, 0, 16'h0000, ST_RUN,   0, "t2 run");

        // length over the limit, then recovery
        tick(1, 12'd2049, 0, 16'h0000, ST_RUN, 0, "t3 start");
        tick(0, 12'd0, 1, 16'h4444, ST_ERR,    0, "t3 err0");
        tick(0, 12'd0, 0, 16'h0000, ST_ERR,    0, "t3 err1");
        tick(1, 12'd1, 0, 16'h0000, ST_ERR,    0, "t3 restart");
        tick(0, 12'd0, 1, 16'h0F0F, ST_LOAD,   1, "t3 w0");
        tick(0, 12'd0, 0, 16'h0000, ST_FLUSH,  0, "t3 flush");
        tick(0, 12'd0, 0, 16'h0000, ST_RUN,    0, "t3 run");

`ifdef PROG_CHECKSUM_EN
        tick(1, 12'd2, 0, 16'h0000, ST_RUN,   0, "c1 start");
        tick(0, 12'd0, 1, 16'h0001, ST_LOAD,  1, "c1 w0");
        tick(0, 12'd0, 1, 16'h0002, ST_LOAD,  1, "c1 w1");
        tick(0, 12'd0, 1, 16'hFFFD, ST_LOAD,  0, "c1 chk");
        tick(0, 12'd0, 0, 16'h0000, ST_FLUSH, 0, "c1 flush");
        tick(0, 12'd0, 0, 16'h0000, ST_RUN,   0, "c1 run");
        tick(1, 12'd2, 0, 16'h0000, ST_RUN,   0, "c2 start");
        tick(0, 12'd0, 1, 16'h0001, ST_LOAD,  1, "c2 w0");
        tick(0, 12'd0, 1, 16'h0002, ST_LOAD,  1, "c2 w1");
        tick(0, 12'd0, 1, 16'h0000, ST_LOAD,  0, "c2 chk");
        tick(0, 12'd0, 0, 16'h0000, ST_ERR,   0, "c2 err");
        tick(1, 12'd0, 0, 16'h0000, ST_ERR,   0, "c3 start");
        tick(0, 12'd0, 1, 16'h0000, ST_LOAD,  0, "c3 chk");
        tick(0, 12'd0, 0, 16'h0000, ST_FLUSH, 0, "c3 flush");
        tick(0, 12'd0, 0, 16'h0000, ST_RUN,   0, "c3 run");
`else
        tick(1, 12'd0, 0, 16'h0000, ST_RUN,   0, "z start");
        tick(0, 12'd0, 1, 16'h9999, ST_RUN,   0, "z run");
`endif

        // reset in the middle of a four-word load
        tick(1, 12'd4, 0, 16'h0000, ST_RUN,   0, "r start");
        tick(0, 12'd0, 1, 16'h1234, ST_LOAD,  1, "r w0");
        tick(0, 12'd0, 0, 16'h0000, ST_LOAD,  0, "r hold");
        rstz = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h5678;
        #1;
        chk_status("mid reset", ST_IDLE);
        chk("mid reset mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("mid reset mem_wdata", {16'b0, bus.mem_wdata}, 32'd0);
        chk("mid reset mem_addr", {16'b0, bus.mem_addr}, {16'b0, START});
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        rstz = 1'b1;
        tick(0, 12'd0, 1, 16'h5678, ST_IDLE,  0, "after reset");
        tick(0, 12'd0, 0, 16'h0000, ST_IDLE,  0, "idle");

        chk("pending writes", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
